// File: rtl/bin_to_gray_tx.sv
// Binary-to-Gray encoder with stream and free-running count sources feeding a 2-entry output FIFO.
// Latency 1 cycle from acceptance to out_*; a full FIFO takes a push only alongside a pop.
module bin_to_gray_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  input  logic             cnt_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_adj
);

  typedef enum logic [1:0] {STREAM, DRAIN, COUNT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem_gray [2];
  logic [WIDTH-1:0] mem_bin  [2];
  logic             mem_adj  [2];
  logic             rd_ptr, wr_ptr;
  logic [1:0]       occ;
  logic [WIDTH-1:0] cnt, prev_gray;

  logic             empty, full, pop, space, push, push_cnt;
  logic [WIDTH-1:0] push_bin, push_gray, gray_diff;
  logic             push_adj;

  assign empty     = (occ == 2'd0);
  assign full      = (occ == 2'd2);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign space     = !full || pop;

  // rst_n gates in_ready so it reads 0 while reset is held, not just after.
  assign in_ready  = rst_n && (state == STREAM) && space;
  assign push_cnt  = (state == COUNT) && cnt_en && space;
  assign push      = (in_valid && in_ready) || push_cnt;

  assign push_bin  = (state == COUNT) ? cnt : in_bin;
  assign push_gray = push_bin ^ (push_bin >> 1);
  assign gray_diff = push_gray ^ prev_gray;
  assign push_adj  = (gray_diff != '0) && ((gray_diff & (gray_diff - 1'b1)) == '0);

  assign out_gray  = empty ? '0 : mem_gray[rd_ptr];
  assign out_bin   = empty ? '0 : mem_bin[rd_ptr];
  assign out_adj   = empty ? 1'b0 : mem_adj[rd_ptr];

  always_comb begin
    state_nxt = state;
    case (state)
      STREAM: if (mode) state_nxt = DRAIN;
      DRAIN: begin
        if (!mode)      state_nxt = STREAM;
        else if (empty) state_nxt = COUNT;
      end
      COUNT:  if (!mode) state_nxt = DRAIN;
      default: state_nxt = STREAM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STREAM;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      occ       <= 2'd0;
      cnt       <= '0;
      prev_gray <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_gray[i] <= '0;
        mem_bin[i]  <= '0;
        mem_adj[i]  <= 1'b0;
      end
    end else begin
      state <= state_nxt;
      if (push) begin
        mem_gray[wr_ptr] <= push_gray;
        mem_bin[wr_ptr]  <= push_bin;
        mem_adj[wr_ptr]  <= push_adj;
        wr_ptr           <= ~wr_ptr;
        prev_gray        <= push_gray;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push_cnt) cnt <= cnt + 1'b1;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bin_to_gray_tx.sv
// Directed bench for bin_to_gray_tx (WIDTH=4): stream, backpressure, full-FIFO streaming, drain, count wrap, reset.
module tb_bin_to_gray_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_bin = 4'd0;
  logic       cnt_en = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_gray;
  logic [3:0] out_bin;
  logic       out_adj;

  int checks = 0;
  int failures = 0;
  logic [3:0] q[$];

  bin_to_gray_tx #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_bin(in_bin), .cnt_en(cnt_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_gray(out_gray), .out_bin(out_bin), .out_adj(out_adj)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Steps until the head carries bin value b, within lim cycles.
  task automatic wait_bin(input logic [3:0] b, input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      step();
      if (out_valid && out_bin == b) ok = 1'b1;
    end
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  logic       ok;
  logic [3:0] r;

  initial begin
    // Reset values while held low
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_gray",  32'(out_gray),  32'd0);
    chk("rst_out_bin",   32'(out_bin),   32'd0);
    chk("rst_out_adj",   32'(out_adj),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic stream encoding
    out_ready = 1'b1; in_valid = 1'b1; in_bin = 4'b1011;
    step();
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_gray",  32'(out_gray),  32'b1110);
    chk("s1_bin",   32'(out_bin),   32'b1011);
    chk("s1_adj",   32'(out_adj),   32'd0);
    in_bin = 4'b1010;
    step();
    chk("s2_gray", 32'(out_gray), 32'b1111);
    chk("s2_adj",  32'(out_adj),  32'd1);
    in_valid = 1'b0;
    step();
    chk("s_drained", 32'(out_valid), 32'd0);

    // Backpressure holds the head and fills the FIFO
    out_ready = 1'b0; in_valid = 1'b1; in_bin = 4'd3;
    step();
    in_bin = 4'd7;
    step();
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_gray_head",     32'(out_gray), 32'b0010);
    in_valid = 1'b0;
    step();
    chk("bp_gray_hold", 32'(out_gray), 32'b0010);
    out_ready = 1'b1;
    #1;
    chk("bp_first", 32'(out_gray), 32'b0010);
    step();
    chk("bp_second", 32'(out_gray), 32'b0100);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Fill, then push and pop together on the full FIFO
    out_ready = 1'b0; in_valid = 1'b1; in_bin = 4'd5;
    step();
    in_bin = 4'd9;
    step();
    q.push_back(4'd5);
    q.push_back(4'd9);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r = 4'($urandom_range(0, 15));
      in_bin = r;
      #1;
      chk("full_in_ready", 32'(in_ready), 32'd1);
      chk("full_bin",      32'(out_bin),  32'(q[0]));
      chk("full_gray",     32'(out_gray), 32'(g(q[0])));
      q.push_back(r);
      step();
      void'(q.pop_front());
    end

    // Mode switch with two entries held: nothing from the counter until drained
    out_ready = 1'b0; in_bin = 4'hA; mode = 1'b1; cnt_en = 1'b1;
    step();
    chk("dr_in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    chk("dr_head_held", 32'(out_bin),   32'(q[0]));
    chk("dr_valid",     32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("dr_in_ready_pop", 32'(in_ready), 32'd0);
    step();
    chk("dr_second", 32'(out_bin), 32'(q[1]));
    step();
    chk("dr_empty_a", 32'(out_valid), 32'd0);
    step();
    chk("dr_empty_b", 32'(out_valid), 32'd0);
    step();
    chk("cnt_first_bin",  32'(out_bin),  32'd0);
    chk("cnt_first_gray", 32'(out_gray), 32'd0);
    chk("cnt_in_ready",   32'(in_ready), 32'd0);
    step();
    chk("cnt_second_gray", 32'(out_gray), 32'b0001);
    chk("cnt_second_adj",  32'(out_adj),  32'd1);
    in_valid = 1'b0;

    // Count through a full wrap from a clean reset
    pulse_reset();
    wait_bin(4'd0, 10, ok);
    chk("wrap_start", 32'(ok), 32'd1);
    for (int k = 0; k < 17; k++) begin
      chk("wrap_bin",  32'(out_bin),  32'(k % 16));
      chk("wrap_gray", 32'(out_gray), 32'(g(4'(k % 16))));
      chk("wrap_adj",  32'(out_adj),  (k == 0) ? 32'd0 : 32'd1);
      step();
    end

    // Reset in the middle of counting
    pulse_reset();
    wait_bin(4'd8, 40, ok);
    chk("mid_reach_cnt9", 32'(ok), 32'd1);
    chk("mid_nonempty",   32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    32'(out_valid), 32'd0);
    chk("mid_rst_gray",     32'(out_gray),  32'd0);
    chk("mid_rst_in_ready", 32'(in_ready),  32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_release_in_ready", 32'(in_ready), 32'd1);
    wait_bin(4'd0, 10, ok);
    chk("mid_restart",      32'(ok),       32'd1);
    chk("mid_restart_gray", 32'(out_gray), 32'd0);
    chk("mid_restart_adj",  32'(out_adj),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
